// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the AXI interconnect arbiters.
package axi_ic_pkg;

    localparam int NUM_M = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam logic [NUM_M-1:0] GNT_NONE = 3'b000;
    localparam logic [NUM_M-1:0] GNT_M0   = 3'b001;
    localparam logic [NUM_M-1:0] GNT_M1   = 3'b010;
    localparam logic [NUM_M-1:0] GNT_M2   = 3'b100;

    function automatic logic [NUM_M-1:0] idx2oh(input logic [1:0] idx);
        case (idx)
            2'd0:    idx2oh = GNT_M0;
            2'd1:    idx2oh = GNT_M1;
            2'd2:    idx2oh = GNT_M2;
            default: idx2oh = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rd_rr_picker.sv
// Combinational round-robin picker: first requester scanning cyclically after last_owner.
module rd_rr_picker
    import axi_ic_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [1:0]       last_owner,
    output logic [NUM_M-1:0] gnt,
    output logic [1:0]       idx,
    output logic             any_req
);

    logic [2:0] cand;
    logic       found;

    always_comb begin
        gnt     = GNT_NONE;
        idx     = last_owner;
        any_req = |req;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = {1'b0, last_owner} + 3'(i);
            if (cand >= 3'(NUM_M)) begin
                cand = cand - 3'(NUM_M);
            end
            if (!found && req[cand[1:0]]) begin
                found = 1'b1;
                idx   = cand[1:0];
            end
        end
        if (found) begin
            gnt = idx2oh(idx);
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin read-channel arbiter: one grant per AR..last-R transaction, with stall watchdog.
module axi_rd_arbiter
    import axi_ic_pkg::*;
#(
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             rd_req_0,
    input  logic             rd_req_1,
    input  logic             rd_req_2,
    input  logic             s_arvalid,
    input  logic             m_arready,
    input  logic             m_rvalid,
    input  logic             s_rready,
    input  logic             rd_state_refre,
    output logic [NUM_M-1:0] rd_grant,
    output logic             rd_busy,
    output logic             rd_timeout,
    output logic [1:0]       rd_last_owner
);

    // state   | meaning
    // IDLE    | no owner; arbitrate among requests
    // ADDR    | owner granted, waiting for AR handshake
    // DATA    | AR accepted, streaming R beats until refre

    rd_state_e        state;
    logic [TO_W-1:0]  wd_cnt;
    logic [TO_W-1:0]  wd_inc;
    logic             wd_expire;
    logic [NUM_M-1:0] req_vec;
    logic [NUM_M-1:0] pick_gnt;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             ar_hs;
    logic             r_hs;

    assign req_vec   = {rd_req_2, rd_req_1, rd_req_0};
    assign owner_req = |(req_vec & rd_grant);
    assign ar_hs     = s_arvalid && m_arready;
    assign r_hs      = m_rvalid && s_rready;
    assign wd_inc    = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;
    // Expiry fires on the TO_LIMIT-th consecutive stalled cycle.
    assign wd_expire = (TO_LIMIT != 0) && (wd_inc == TO_W'(TO_LIMIT));

    rd_rr_picker u_picker (
        .req        (req_vec),
        .last_owner (rd_last_owner),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .any_req    (pick_any)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            rd_grant      <= GNT_NONE;
            rd_busy       <= 1'b0;
            rd_timeout    <= 1'b0;
            rd_last_owner <= 2'd2;
            wd_cnt        <= '0;
        end else begin
            rd_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state         <= ST_ADDR;
                        rd_grant      <= pick_gnt;
                        rd_last_owner <= pick_idx;
                        rd_busy       <= 1'b1;
                        wd_cnt        <= '0;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        state  <= ST_DATA;
                        wd_cnt <= '0;
                    end else if (!owner_req || wd_expire) begin
                        state      <= ST_IDLE;
                        rd_grant   <= GNT_NONE;
                        rd_busy    <= 1'b0;
                        rd_timeout <= owner_req;
                        wd_cnt     <= '0;
                    end else begin
                        wd_cnt <= wd_inc;
                    end
                end
                ST_DATA: begin
                    if (rd_state_refre) begin
                        state    <= ST_IDLE;
                        rd_grant <= GNT_NONE;
                        rd_busy  <= 1'b0;
                        wd_cnt   <= '0;
                    end else if (r_hs) begin
                        wd_cnt <= '0;
                    end else if (wd_expire) begin
                        state      <= ST_IDLE;
                        rd_grant   <= GNT_NONE;
                        rd_busy    <= 1'b0;
                        rd_timeout <= 1'b1;
                        wd_cnt     <= '0;
                    end else begin
                        wd_cnt <= wd_inc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    rd_grant <= GNT_NONE;
                    rd_busy  <= 1'b0;
                    wd_cnt   <= '0;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge sys_clk) disable iff (sys_rst)
        $onehot0(rd_grant));
    a_grant_idle: assert property (@(posedge sys_clk) disable iff (sys_rst)
        ((rd_grant == GNT_NONE) == (state == ST_IDLE)));

endmodule
